// File: rtl/data_mmio.sv
// data_mmio: memory-mapped peripheral block on the core data port.
// It contains a byte-wide console TX FIFO, a 64-bit mtime/mtimecmp timer
// with an interrupt, and a sticky halt register. Reads are combinational
// and writes commit on the rising clock edge.
module data_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TICK_DIV   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        sel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [5:0] OFF_TXDATA  = 6'h00;
  localparam logic [5:0] OFF_STATUS  = 6'h01;
  localparam logic [5:0] OFF_MTIMELO = 6'h02;
  localparam logic [5:0] OFF_MTIMEHI = 6'h03;
  localparam logic [5:0] OFF_CMPLO   = 6'h04;
  localparam logic [5:0] OFF_CMPHI   = 6'h05;
  localparam logic [5:0] OFF_HALT    = 6'h06;

  // Replace only the byte lanes whose mask bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [5:0]  off;
  logic        wr_any;
  logic        unused_addr_lsb;

  assign off             = addr[7:2];
  assign sel             = (addr[31:8] == BASE_ADDR[31:8]);
  assign wr_any          = wen && sel && (wmask != 4'h0);
  assign unused_addr_lsb = ^addr[1:0];

  // ---------------- TX FIFO ----------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, count;
  logic        full, empty, push_req, push, pop, ovf, ovf_clr;

  assign count    = wptr - rptr;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_req = wr_any && (off == OFF_TXDATA) && wmask[0];
  assign pop      = !empty && tx_ready;
  // A pop frees the slot in the same edge, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign ovf_clr  = wr_any && (off == OFF_STATUS) && wmask[0] && wdata[3];
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : mem[rptr[AW-1:0]];

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata[7:0];
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (ovf_clr)             ovf <= 1'b0;
    end
  end

  // ---------------- Timer ----------------
  logic [PW-1:0] presc;
  logic          tick;
  logic [63:0]   mtime, mtimecmp;
  logic          wr_mlo, wr_mhi, wr_clo, wr_chi;

  assign tick   = (presc == PW'(TICK_DIV - 1));
  assign wr_mlo = wr_any && (off == OFF_MTIMELO);
  assign wr_mhi = wr_any && (off == OFF_MTIMEHI);
  assign wr_clo = wr_any && (off == OFF_CMPLO);
  assign wr_chi = wr_any && (off == OFF_CMPHI);

  // Prescaler runs freely; mtime writes do not disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // mtime: a software write to either half suppresses that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= '0;
    end else if (wr_mlo || wr_mhi) begin
      if (wr_mlo) mtime[31:0]  <= merge_bytes(mtime[31:0],  wdata, wmask);
      if (wr_mhi) mtime[63:32] <= merge_bytes(mtime[63:32], wdata, wmask);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp halves and the registered interrupt comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      if (wr_clo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0],  wdata, wmask);
      if (wr_chi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata, wmask);
      timer_irq <= (mtime >= mtimecmp);
    end
  end

  // ---------------- Halt ----------------
  // Only the first effective write is captured; later ones are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt      <= 1'b0;
      halt_code <= '0;
    end else if (!halt && wr_any && (off == OFF_HALT)) begin
      halt      <= 1'b1;
      halt_code <= merge_bytes(32'h0, wdata, wmask);
    end
  end

  // Combinational read mux; zero outside the window or at unmapped offsets.
  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (off)
        OFF_STATUS:  rdata = {16'h0, 8'(count), 4'h0, ovf, timer_irq, empty, full};
        OFF_MTIMELO: rdata = mtime[31:0];
        OFF_MTIMEHI: rdata = mtime[63:32];
        OFF_CMPLO:   rdata = mtimecmp[31:0];
        OFF_CMPHI:   rdata = mtimecmp[63:32];
        OFF_HALT:    rdata = halt_code;
        default:     rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mmio.sv
// Testbench for data_mmio: scoreboard of expected TX bytes plus directed
// register, timer and halt checks.
module tb_data_mmio;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;

  logic        clk, rst_n;
  logic [31:0] addr, wdata, rdata, halt_code;
  logic [3:0]  wmask;
  logic        wen, sel, tx_valid, tx_ready, timer_irq, halt;
  logic [7:0]  tx_data;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  sb [$];
  logic        ovf_m;
  logic [31:0] rv;

  data_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .TICK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wmask(wmask),
    .wen(wen), .rdata(rdata), .sel(sel), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .timer_irq(timer_irq),
    .halt(halt), .halt_code(halt_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected STATUS word from the bench's own FIFO model.
  function automatic logic [31:0] exp_status(input logic irq);
    return {16'h0, 8'(sb.size()), 4'h0, ovf_m, irq, (sb.size() == 0), (sb.size() == DEPTH)};
  endfunction

  // Drive one write for one clock; update the FIFO/ovf model as it is issued.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; wmask = m; wen = 1'b1;
    if (a[31:8] == BASE[31:8] && m != 4'h0) begin
      if (a[7:2] == 6'h00 && m[0]) begin
        if (sb.size() < DEPTH || (tx_ready && sb.size() > 0)) sb.push_back(d[7:0]);
        else ovf_m = 1'b1;
      end else if (a[7:2] == 6'h01 && m[0] && d[3]) begin
        ovf_m = 1'b0;
      end
    end
    @(posedge clk); #1;
    wen = 1'b0; wmask = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; wen = 1'b0;
    #1;
    d = rdata;
  endtask

  // Drain the FIFO with a bounded wait, then confirm nothing is left.
  task automatic drain(input string tag);
    int k = 0;
    tx_ready = 1'b1;
    while (sb.size() > 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    tx_ready = 1'b0;
    chk({tag, "_pending"}, sb.size(), 0);
    chk({tag, "_valid"}, tx_valid, 0);
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (sb.size() == 0) chk("tx_unexp_valid", tx_valid, 0);
      else chk("tx_data", tx_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    clk = 0; rst_n = 0; addr = 0; wdata = 0; wmask = 0; wen = 0; tx_ready = 0;
    ovf_m = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_irq", timer_irq, 0);
    chk("rst_halt", halt, 0);
    chk("rst_halt_code", halt_code, 0);
    rd(32'h0000_0000, rv);
    chk("rst_sel_out", sel, 0);
    chk("rdata_unsel", rv, 0);
    rd(BASE + 32'h04, rv);
    chk("rst_status", rv, 32'h0000_0002);
    chk("sel_in", sel, 1);
    rd(BASE + 32'h1C, rv);
    chk("unmapped_rd", rv, 0);

    // Byte-masked mtimecmp write, then a write outside the window
    wr(BASE + 32'h10, 32'hAABB_CCDD, 4'b0101);
    rd(BASE + 32'h10, rv);
    chk("cmp_lo_mask", rv, 32'hFFBB_FFDD);
    rd(BASE + 32'h14, rv);
    chk("cmp_hi_rst", rv, 32'hFFFF_FFFF);
    wr(32'h2000_0010, 32'h0, 4'hF);
    rd(BASE + 32'h10, rv);
    chk("cmp_lo_unsel_wr", rv, 32'hFFBB_FFDD);

    // FIFO drain on consecutive cycles
    wr(BASE, 32'h41, 4'h1);
    wr(BASE, 32'h42, 4'h1);
    wr(BASE, 32'h43, 4'h1);
    rd(BASE + 32'h04, rv);
    chk("status_3", rv, exp_status(1'b0));
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    chk("drain3_valid", tx_valid, 0);
    chk("drain3_pending", sb.size(), 0);

    // Overflow: 9 pushes into 8 entries
    for (int i = 1; i <= 9; i++) wr(BASE, 32'(i), 4'h1);
    rd(BASE + 32'h04, rv);
    chk("status_ovf", rv, exp_status(1'b0));
    drain("drain_ovf");
    wr(BASE + 32'h04, 32'h8, 4'h1);
    rd(BASE + 32'h04, rv);
    chk("status_ovf_clr", rv, exp_status(1'b0));

    // Full FIFO: push and pop in the same edge
    for (int i = 0; i < 8; i++) wr(BASE, 32'h10 + 32'(i), 4'h1);
    rd(BASE + 32'h04, rv);
    chk("status_full", rv, exp_status(1'b0));
    tx_ready = 1'b1;
    wr(BASE, 32'hAA, 4'h1);
    tx_ready = 1'b0;
    rd(BASE + 32'h04, rv);
    chk("status_full_pp", rv, exp_status(1'b0));
    drain("drain_pp");

    // Timer compare at 20 with TICK_DIV=1
    wr(BASE + 32'h0C, 32'h0, 4'hF);
    wr(BASE + 32'h14, 32'h0, 4'hF);
    wr(BASE + 32'h10, 32'd20, 4'hF);
    wr(BASE + 32'h08, 32'h0, 4'hF);
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      chk($sformatf("irq_e%0d", k), timer_irq, (k >= 21));
    end
    rd(BASE + 32'h04, rv);
    chk("status_irq", rv, exp_status(1'b1));
    rd(BASE + 32'h08, rv);
    chk("mtime_lo", rv, 32'd21);
    wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #1;
    chk("irq_deassert", timer_irq, 0);

    // Halt register
    wr(BASE + 32'h18, 32'h5, 4'h0);
    chk("halt_nomask", halt, 0);
    wr(BASE + 32'h18, 32'h1, 4'hF);
    chk("halt_set", halt, 1);
    chk("halt_code_1", halt_code, 32'h1);
    wr(BASE + 32'h18, 32'h2, 4'hF);
    chk("halt_code_keep", halt_code, 32'h1);
    rd(BASE + 32'h18, rv);
    chk("halt_rd", rv, 32'h1);

    // Reset mid-operation discards FIFO contents and halt
    wr(BASE, 32'h55, 4'h1);
    wr(BASE, 32'h66, 4'h1);
    chk("pre_rst_valid", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    ovf_m = 1'b0;
    chk("async_rst_valid", tx_valid, 0);
    chk("async_rst_halt", halt, 0);
    chk("async_rst_code", halt_code, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(BASE + 32'h04, rv);
    chk("status_post_rst", rv, exp_status(1'b0));

    // Halt with partial byte mask
    wr(BASE + 32'h18, 32'hAABB_CCDD, 4'b0110);
    chk("halt_mask_code", halt_code, 32'h00BB_CC00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/data_mmio.md
# data_mmio

Memory-mapped peripheral responder on the core's data port. It sits in parallel with `data_mem` behind an address decode. It provides:
- a byte-wide console TX FIFO with a valid/ready drain port;
- a free-running 64-bit `mtime` timer with `mtimecmp` and a timer interrupt;
- a sticky simulation-halt register that benches use to end a test.

Reads are combinational, to suit the single-cycle core. Writes commit on the rising clock edge.

## Interface
Parameters:
- `BASE_ADDR`, 32'h1000_0000, base of the 256-byte window; bits [7:0] must be zero.
- `FIFO_DEPTH`, 8, TX FIFO entries; must be a power of two, ≥2.
- `TICK_DIV`, 1, number of clk cycles per `mtime` increment; ≥1.

Ports:
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `addr` in 32: byte address from the core.
- `wdata` in 32: write data.
- `wmask` in 4: byte-lane write enables; bit i covers wdata[8i+7:8i].
- `wen` in 1: write strobe.
- `rdata` out 32: read data, combinational.
- `sel` out 1: high when `addr[31:8]==BASE_ADDR[31:8]`. The top level uses it for the rdata mux.
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO not empty.
- `tx_ready` in 1: sink accepts the head byte.
- `timer_irq` out 1: registered `mtime >= mtimecmp`.
- `halt` out 1: sticky halt request.
- `halt_code` out 32: code captured by the first HALT write.

## Operation
Register map, word offset `addr[7:2]`. `addr[1:0]` is ignored. Unmapped offsets read 0 and ignore writes.

- **0x00 TXDATA**
  - A write with `wmask[0]=1` pushes `wdata[7:0]`.
  - A push while full is dropped and sets sticky `ovf`.
  - Reads return 0.
- **0x04 STATUS**
  - Read layout: `[15:8]`=count, `[3]`=ovf, `[2]`=timer_irq, `[1]`=empty, `[0]`=full.
  - A write with `wmask[0]=1` and `wdata[3]=1` clears ovf. All other bits are read-only.
- **0x08 MTIME_LO, 0x0C MTIME_HI**
  - Byte-masked writes.
  - A write in the same cycle as an increment wins; the increment is lost.
  - The two halves are written independently (non-atomic).
- **0x10 MTIMECMP_LO, 0x14 MTIMECMP_HI**
  - Byte-masked writes.
- **0x18 HALT**
  - The first write with any wmask bit set latches `halt=1` and `halt_code` = masked wdata (unmasked lanes 0).
  - Later writes are ignored until reset.
  - Reads return `halt_code`.

Other behaviour:
- `wen` with `wmask=0`, or with `sel=0`, has no effect.
- `rdata=0` whenever `sel=0`.
- **Timer**
  - A prescaler counts 0..TICK_DIV-1. `mtime` increments when the prescaler wraps.
  - A write to MTIME_LO/HI does not reset the prescaler.
  - `mtime` wraps from 2^64-1 to 0.
- **FIFO**
  - Circular buffer, read/write pointers with log2(FIFO_DEPTH)+1 bits, count 0..FIFO_DEPTH.
  - A pop occurs on a clock edge with `tx_valid && tx_ready`.
  - Simultaneous push and pop:
    - when full: both occur, count unchanged, no ovf;
    - when empty: only the push occurs.
  - No write-to-`tx_data` bypass.

Reset values:
- FIFO empty, ovf 0.
- `mtime` 0, prescaler 0, `mtimecmp` all-ones.
- `timer_irq` 0, `halt` 0, `halt_code` 0.
- Outputs: `tx_valid` 0, `tx_data` 0.

An asserted `rst_n` mid-operation discards FIFO contents immediately.

## Timing
- Read path: `addr` → `rdata`/`sel` is combinational, same cycle.
- A write committed at edge E is visible on `rdata` after E.
- Push at edge E → `tx_valid` high after E. Pop at edge E → the next head appears after E.
- `timer_irq` is registered from the current `mtime`/`mtimecmp`. It lags the comparison by one cycle and deasserts the same way.
- `halt`/`halt_code` update at the write edge.

## Test plan
1. **Reset.** Release `rst_n`; read offset 0x04.
   - Expect STATUS=0x0000_0002, `tx_valid`=0, `timer_irq`=0, `halt`=0, `sel`=0 for `addr`=0x0000_0000.
2. **FIFO drain.** Hold `tx_ready`=0; write 0x41, 0x42, 0x43 to TXDATA.
   - Expect STATUS[15:8]=3.
   - Raise `tx_ready`: expect `tx_data` 0x41, 0x42, 0x43 on three consecutive cycles, then `tx_valid`=0.
3. **Overflow.** With `tx_ready`=0, push 9 bytes 0x01..0x09.
   - Expect full=1, ovf=1, count=8.
   - Drain: expect 0x01..0x08 only.
   - Write STATUS with 0x8 (`wmask[0]=1`): expect ovf=0.
4. **Full push+pop.** With the FIFO full, push 0xAA in the same cycle as a pop.
   - Expect count stays 8, ovf=0, and 0xAA is the last byte drained.
5. **Timer** (TICK_DIV=1). Write MTIMECMP_HI=0, MTIMECMP_LO=20, then MTIME_LO=0 at edge E.
   - Expect `timer_irq` 0 through E+20 and 1 after edge E+21.
   - Write MTIMECMP_LO=0xFFFF_FFFF: expect `timer_irq`=0 one cycle later.
6. **Byte masks and halt.**
   - From reset, write MTIMECMP_LO=0xAABB_CCDD with `wmask`=4'b0101: expect readback 0xFFBB_FFDD.
   - Write HALT=0x1: expect `halt`=1, `halt_code`=1.
   - Write HALT=0x2: `halt_code` stays 1.
   - Pulse `rst_n`: expect `halt`=0.
